axi_line_fetcher: RTL

- Single-line read buffer between a 32-bit word requester (core/PIM load port) and the 512-bit AXI4 read channels of the downstream memory slave.
- On a miss, it fetches one 64-byte line as a single-beat INCR burst and returns the addressed 32-bit word.
- Hits are served from the held line with no AXI traffic.
- Read-only; it has no AXI write channels.

---
 rtl/axi_line_fetcher_if.sv | 54 +++++
 rtl/axi_line_fetcher.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/axi_line_fetcher_if.sv
// ---------------------------------------------------------------------------
// axi_line_fetcher_if
// Purpose : bundles the word-requester handshake, the flush strobe and the
//           AXI4 read address/data channels used by axi_line_fetcher.
// Modports: master - the line fetcher (answers requests, drives AR, sinks R)
//           slave  - the environment (requester plus downstream AXI slave)
// Signals : req_valid/req_ready/req_addr  word read request
//           rsp_valid/rsp_ready/rsp_data/rsp_err  word response
//           flush                          invalidate held line
//           m_axi_ar*/m_axi_r*             AXI4 read channels (512-bit data)
// ---------------------------------------------------------------------------
interface axi_line_fetcher_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_data;
  logic                  rsp_err;
  logic                  flush;

  logic [ID_WIDTH-1:0]   m_axi_arid;
  logic [ADDR_WIDTH-1:0] m_axi_araddr;
  logic [7:0]            m_axi_arlen;
  logic [2:0]            m_axi_arsize;
  logic [1:0]            m_axi_arburst;
  logic                  m_axi_arvalid;
  logic                  m_axi_arready;
  logic [ID_WIDTH-1:0]   m_axi_rid;
  logic [511:0]          m_axi_rdata;
  logic [1:0]            m_axi_rresp;
  logic                  m_axi_rlast;
  logic                  m_axi_rvalid;
  logic                  m_axi_rready;

  modport master (
    input  req_valid, req_addr, rsp_ready, flush,
    input  m_axi_arready, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output req_ready, rsp_valid, rsp_data, rsp_err,
    output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
    output m_axi_arvalid, m_axi_rready
  );

  modport slave (
    output req_valid, req_addr, rsp_ready, flush,
    output m_axi_arready, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
    input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
    input  m_axi_arvalid, m_axi_rready
  );
endinterface

// File: rtl/axi_line_fetcher.sv
// ---------------------------------------------------------------------------
// axi_line_fetcher
// Purpose : single-line read buffer. A 32-bit word request that hits the held
//           64-byte line is answered locally (1-cycle latency); a miss fetches
//           the line as one 512-bit AXI4 INCR beat and returns the word.
// Ports   : clk        clock (rising edge)
//           rst        asynchronous active-high reset
//           bus        axi_line_fetcher_if.master (request/response, flush,
//                      AXI4 read address and read data channels)
//           hit_count  accepted hits   (0 unless LINE_STATS_EN)
//           miss_count accepted misses (0 unless LINE_STATS_EN)
// Options : define LINE_STATS_EN to build saturating hit/miss counters.
// ---------------------------------------------------------------------------
module axi_line_fetcher #(
  parameter int                  ADDR_WIDTH = 32,
  parameter int                  ID_WIDTH   = 8,
  parameter logic [ID_WIDTH-1:0] AXI_ID     = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  axi_line_fetcher_if.master     bus,
  output logic [31:0]            hit_count,
  output logic [31:0]            miss_count
);
  localparam int TAG_W = ADDR_WIDTH - 6;

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_RESP} state_t;

  state_t                r_state;
  state_t                w_state_next;

  logic                  r_line_valid;
  logic [TAG_W-1:0]      r_line_tag;
  logic [511:0]          r_line_data;
  logic [TAG_W-1:0]      r_tag;          // tag of the request being served
  logic [3:0]            r_word;         // word index of the request being served
  logic [31:0]           r_rsp_data;
  logic                  r_rsp_err;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic                  r_arvalid;
  logic                  r_rready;
  logic                  r_first;        // next R beat is the one carrying the line
  logic                  r_flush_pend;   // flush seen while the fetch was in flight

  logic [31:0]           w_rwords [16];
  logic [31:0]           w_lwords [16];
  logic [TAG_W-1:0]      w_req_tag;
  logic [3:0]            w_req_word;
  logic                  w_accept;
  logic                  w_hit;
  logic                  w_ar_hs;
  logic                  w_r_hs;
  logic                  w_flush_seen;
  logic                  w_unused;

  // Word views of the incoming beat and of the held line.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_words
      assign w_rwords[gi] = bus.m_axi_rdata[32*gi +: 32];
      assign w_lwords[gi] = r_line_data[32*gi +: 32];
    end
  endgenerate

  assign w_req_tag    = bus.req_addr[ADDR_WIDTH-1:6];
  assign w_req_word   = bus.req_addr[5:2];
  assign w_accept     = (r_state == S_IDLE) && bus.req_valid;
  // A flush in the acceptance cycle must win over the still-valid line.
  assign w_hit        = r_line_valid && (r_line_tag == w_req_tag) && !bus.flush;
  assign w_ar_hs      = r_arvalid && bus.m_axi_arready;
  assign w_r_hs       = r_rready && bus.m_axi_rvalid;
  assign w_flush_seen = r_flush_pend || bus.flush;
  assign w_unused     = &{1'b0, bus.m_axi_rid, bus.req_addr[1:0]};

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept)                      w_state_next = w_hit ? S_RESP : S_AR;
      S_AR:   if (w_ar_hs)                       w_state_next = S_R;
      S_R:    if (w_r_hs && bus.m_axi_rlast)     w_state_next = S_RESP;
      S_RESP: if (bus.rsp_ready)                 w_state_next = S_IDLE;
      default:                                   w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_line_valid <= 1'b0;
      r_line_tag   <= '0;
      r_line_data  <= '0;
      r_tag        <= '0;
      r_word       <= '0;
      r_rsp_data   <= '0;
      r_rsp_err    <= 1'b0;
      r_araddr     <= '0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_first      <= 1'b0;
      r_flush_pend <= 1'b0;
    end else begin
      if (bus.flush) r_line_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_flush_pend <= 1'b0;
          if (w_accept) begin
            r_tag  <= w_req_tag;
            r_word <= w_req_word;
            if (w_hit) begin
              r_rsp_data <= w_lwords[w_req_word];
              r_rsp_err  <= 1'b0;
            end else begin
              r_araddr  <= {w_req_tag, 6'b0};
              r_arvalid <= 1'b1;
            end
          end
        end
        S_AR: begin
          if (bus.flush) r_flush_pend <= 1'b1;
          if (w_ar_hs) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_first   <= 1'b1;
          end
        end
        S_R: begin
          if (bus.flush) r_flush_pend <= 1'b1;
          if (w_r_hs) begin
            r_first <= 1'b0;
            // Only the first beat carries the line; any extra beats are drained.
            if (r_first) begin
              r_rsp_data <= w_rwords[r_word];
              r_rsp_err  <= (bus.m_axi_rresp != 2'b00);
              if (bus.m_axi_rresp == 2'b00) begin
                r_line_data  <= bus.m_axi_rdata;
                r_line_tag   <= r_tag;
                r_line_valid <= !w_flush_seen;
              end else begin
                r_line_valid <= 1'b0;
              end
            end
            if (bus.m_axi_rlast) r_rready <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Held low during reset so every handshake output reads 0 while rst is high.
  assign bus.req_ready     = (r_state == S_IDLE) && !rst;
  assign bus.rsp_valid     = (r_state == S_RESP);
  assign bus.rsp_data      = r_rsp_data;
  assign bus.rsp_err       = r_rsp_err;
  assign bus.m_axi_arid    = AXI_ID;
  assign bus.m_axi_araddr  = r_araddr;
  assign bus.m_axi_arlen   = 8'd0;
  assign bus.m_axi_arsize  = 3'd6;
  assign bus.m_axi_arburst = 2'b01;
  assign bus.m_axi_arvalid = r_arvalid;
  assign bus.m_axi_rready  = r_rready;

`ifdef LINE_STATS_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else if (w_accept) begin
      if (w_hit) begin
        if (r_hit_count != 32'hFFFF_FFFF) r_hit_count <= r_hit_count + 32'd1;
      end else begin
        if (r_miss_count != 32'hFFFF_FFFF) r_miss_count <= r_miss_count + 32'd1;
      end
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif
endmodule
